mf_sync_ctrl: RTL and testbench
===============================

// Module: mf_sync_ctrl
// PURPOSE
//  Sequencing and frame-sync controller for the 1-bit 512-tap matched filter (Re path).
//  - Drives the filter enable and waits for its delay line to fill.
//  - Searches the filter output for a correlation peak above a programmable threshold,
//    then refines the peak inside a window.
//  - Locks to the frame period and flywheels through missed peaks; declares loss of lock
//    after MISS_MAX consecutive misses.
// PARAMETERS
//  W3       32    width of filter output mf_y and of thr/peak_val
//  L        512   filter order; qualified samples needed to fill the delay line
//  WIN      64    peak-refinement window, in qualified samples (>=2)
//  PERIOD   4096  frame length in qualified samples (>WIN, <=2**CNT_W)
//  CNT_W    16    width of sample position counter
//  MISS_MAX 3     consecutive misses in TRACK before lock is dropped (>=1)
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      synchronous active-low reset
//  start      in   1      pulse: begin acquisition (honoured only in IDLE)
//  abort      in   1      return to IDLE from any state
//  thr        in   W3     unsigned detection threshold
//  mf_y       in   W3     signed filter output
//  mf_en      in   1      filter output valid (filter en_o)
//  mf_run     out  1      filter input enable
//  sync_pulse out  1      1-cycle frame-start strobe
//  sync_idx   out  CNT_W  position of the accepted peak
//  peak_val   out  W3     magnitude of the accepted peak
//  locked     out  1      frame lock held
//  state_o    out  3      current state
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE; all outputs, counters and registers = 0.
//  - Qualified sample: a cycle with mf_en=1. Counters advance only on qualified samples.
//  - mag = |mf_y|. For mf_y = -2**(W3-1), mag saturates to 2**(W3-1)-1.
//    hit = mag > thr (strict), so thr=0 accepts any nonzero sample.
//  - cnt is the CNT_W position counter.
//    - Cleared on start.
//    - Increments per qualified sample outside IDLE.
//    - Wraps from PERIOD-1 to 0.
//  - States:
//    IDLE=0   mf_run=0. On start (and abort=0): go to FILL, clear cnt, fill_cnt, miss.
//    FILL=1   mf_run=1. Count qualified samples. After the L-th one, go to SEARCH.
//             Samples during FILL are never tested.
//    SEARCH=2 On a qualified hit: pk=mag, pk_idx=cnt, win=0, go to PEAK.
//    PEAK=3   Each qualified sample: win++. If mag>pk, update pk and pk_idx (strict,
//             so ties keep the earliest). When win reaches WIN-1 (the WIN-th sample
//             after the trigger):
//             - pulse sync_pulse;
//             - sync_idx=pk_idx, peak_val=pk, locked=1, miss=0;
//             - go to TRACK.
//    TRACK=4  On a qualified sample with cnt==pk_idx:
//             - hit:  sync_pulse, peak_val=mag, miss=0.
//             - miss: sync_pulse still asserts (flywheel), peak_val holds, miss++.
//               If miss reaches MISS_MAX: locked=0, go to SEARCH; this final miss
//               produces no sync_pulse.
//  - Outputs are registered. sync_pulse is high exactly one cycle, on the clk edge
//    that consumes the qualifying sample plus 1 (one-cycle latency).
//  - abort=1: next state is IDLE; mf_run=0, locked=0. Other outputs hold except
//    sync_pulse=0. abort beats start in the same cycle.
//  - start outside IDLE is ignored.
//  - Reset mid-operation behaves exactly like power-on reset.
//  - mf_en=0 cycles freeze all counters and the state, except abort and start handling.
//  - PEAK window spanning the cnt wrap: pk_idx keeps the raw wrapped cnt value.
//  - thr and the inputs are sampled each cycle and have no internal latching.
// TESTING
//  1 Reset, start, mf_en=1 constant, mf_y=0
//    -> mf_run=1 from cycle+1; SEARCH after 512 qualified samples; no sync_pulse, locked=0.
//  2 thr=1000; after FILL, mf_y=1500 at cnt=100, 2000 at cnt=110, else 0 (WIN=64)
//    -> one sync_pulse after the 64th sample post-trigger; sync_idx=110, peak_val=2000, locked=1.
//  3 From lock at idx 110, PERIOD=4096: hits each period
//    -> sync_pulse at cnt=110 every 4096 samples.
//    Then 3 periods with mf_y=0 -> 2 flywheel pulses, locked=0 at the third, state=SEARCH.
//  4 mf_y=-2**31 at a tested slot with thr=2**31-2
//    -> counted as hit; peak_val=2**31-1.
//  5 Equal peaks 1500 at cnt=200 and 210 in PEAK
//    -> sync_idx=200.
//    Toggle mf_en 50% -> identical sync_idx, with timing stretched.
//  6 abort and start in the same cycle during TRACK
//    -> IDLE, mf_run=0, locked=0, no sync_pulse.
//    Then rst_n low one cycle during PEAK -> all outputs 0.

Source files
------------

// File: rtl/mf_sync_ctrl.sv
// Sequencing and frame-sync controller for the 1-bit 512-tap matched filter (Re path):
// fills the filter, searches for a correlation peak, refines it and tracks the frame period.
module mf_sync_ctrl #(
    parameter int W3       = 32,
    parameter int L        = 512,
    parameter int WIN      = 64,
    parameter int PERIOD   = 4096,
    parameter int CNT_W    = 16,
    parameter int MISS_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [W3-1:0]        thr,
    input  logic signed [W3-1:0] mf_y,
    input  logic                 mf_en,
    output logic                 mf_run,
    output logic                 sync_pulse,
    output logic [CNT_W-1:0]     sync_idx,
    output logic [W3-1:0]        peak_val,
    output logic                 locked,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        SEARCH = 3'd2,
        PEAK   = 3'd3,
        TRACK  = 3'd4
    } state_t;

    localparam int FILL_W = $clog2(L + 1);
    localparam int WIN_W  = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int MISS_W = $clog2(MISS_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(L - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);

    localparam logic [W3-1:0] MOST_NEG = {1'b1, {(W3-1){1'b0}}};
    localparam logic [W3-1:0] MOST_POS = {1'b0, {(W3-1){1'b1}}};

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [FILL_W-1:0]  fill_cnt;
    logic [WIN_W-1:0]   win;
    logic [MISS_W-1:0]  miss;
    logic [W3-1:0]      pk;
    logic [CNT_W-1:0]   pk_idx;

    logic [W3-1:0]      mag;
    logic               hit;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               pk_better;
    logic [W3-1:0]      pk_upd;
    logic [CNT_W-1:0]   idx_upd;

    // The most negative input has no positive twin, so its magnitude saturates.
    always_comb begin
        mag = mf_y;
        if (mf_y == MOST_NEG) begin
            mag = MOST_POS;
        end else if (mf_y[W3-1]) begin
            mag = W3'(-mf_y);
        end
    end

    always_comb begin
        hit       = (mag > thr);
        cnt_nxt   = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        pk_better = (mag > pk);
        pk_upd    = pk_better ? mag : pk;
        idx_upd   = pk_better ? cnt : pk_idx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            fill_cnt   <= '0;
            win        <= '0;
            miss       <= '0;
            pk         <= '0;
            pk_idx     <= '0;
            mf_run     <= 1'b0;
            sync_pulse <= 1'b0;
            sync_idx   <= '0;
            peak_val   <= '0;
            locked     <= 1'b0;
        end else begin
            sync_pulse <= 1'b0;
            if (abort) begin
                state  <= IDLE;
                mf_run <= 1'b0;
                locked <= 1'b0;
            end else begin
                if (mf_en && state != IDLE) begin
                    cnt <= cnt_nxt;
                end
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= FILL;
                            mf_run   <= 1'b1;
                            cnt      <= '0;
                            fill_cnt <= '0;
                            miss     <= '0;
                        end
                    end
                    FILL: begin
                        if (mf_en) begin
                            if (fill_cnt == FILL_LAST) begin
                                state <= SEARCH;
                            end else begin
                                fill_cnt <= fill_cnt + 1'b1;
                            end
                        end
                    end
                    SEARCH: begin
                        if (mf_en && hit) begin
                            pk     <= mag;
                            pk_idx <= cnt;
                            win    <= '0;
                            state  <= PEAK;
                        end
                    end
                    // The closing sample of the window still competes for the peak.
                    PEAK: begin
                        if (mf_en) begin
                            pk     <= pk_upd;
                            pk_idx <= idx_upd;
                            if (win == WIN_LAST) begin
                                sync_pulse <= 1'b1;
                                sync_idx   <= idx_upd;
                                peak_val   <= pk_upd;
                                locked     <= 1'b1;
                                miss       <= '0;
                                state      <= TRACK;
                            end else begin
                                win <= win + 1'b1;
                            end
                        end
                    end
                    TRACK: begin
                        if (mf_en && cnt == pk_idx) begin
                            if (hit) begin
                                sync_pulse <= 1'b1;
                                peak_val   <= mag;
                                miss       <= '0;
                            end else if (miss == MISS_LAST) begin
                                locked <= 1'b0;
                                miss   <= '0;
                                state  <= SEARCH;
                            end else begin
                                sync_pulse <= 1'b1;
                                miss       <= miss + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_mf_sync_ctrl.sv
// Bench for mf_sync_ctrl: reset/abort vector table, directed frame-sync sequences and
// randomized traffic, all checked against a sample-count based reference model.
module tb_mf_sync_ctrl;

    localparam int W3       = 32;
    localparam int L        = 512;
    localparam int WIN      = 64;
    localparam int PERIOD   = 4096;
    localparam int CNT_W    = 16;
    localparam int MISS_MAX = 3;
    localparam longint MAXPOS = (longint'(1) << (W3 - 1)) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n, start, abort, mf_en;
    logic [W3-1:0]        thr;
    logic signed [W3-1:0] mf_y;
    logic                 mf_run, sync_pulse, locked;
    logic [CNT_W-1:0]     sync_idx;
    logic [W3-1:0]        peak_val;
    logic [2:0]           state_o;

    always #5 clk = ~clk;

    mf_sync_ctrl #(
        .W3(W3), .L(L), .WIN(WIN), .PERIOD(PERIOD), .CNT_W(CNT_W), .MISS_MAX(MISS_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .thr(thr),
        .mf_y(mf_y), .mf_en(mf_en), .mf_run(mf_run), .sync_pulse(sync_pulse),
        .sync_idx(sync_idx), .peak_val(peak_val), .locked(locked), .state_o(state_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: positions derive from the absolute sample count since start.
    int     m_mode, m_n, m_trig, m_best_pos, m_idx, m_miss, m_last_pos;
    bit     m_run, m_sync, m_locked;
    longint m_best, m_peak;

    int pulses = 0;
    int last_pos = -1;
    int pa_pos = -1, pb_pos = -1;
    logic signed [W3-1:0] pa_val = '0, pb_val = '0;
    bit toggle = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint mag_of(input logic signed [W3-1:0] y);
        longint v;
        v = longint'(y);
        if (v < 0) v = -v;
        if (v > MAXPOS) v = MAXPOS;
        return v;
    endfunction

    task automatic model_step();
        m_sync = 1'b0;
        if (!rst_n) begin
            m_mode = 0; m_run = 0; m_locked = 0; m_idx = 0; m_peak = 0;
            m_n = 0; m_best = 0; m_best_pos = 0; m_miss = 0; m_trig = 0;
        end else if (abort) begin
            m_mode = 0; m_run = 0; m_locked = 0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_mode = 1; m_run = 1; m_n = 0;
            end
        end else if (mf_en) begin
            int pos;
            longint mg;
            bit h;
            pos = m_n % PERIOD;
            mg  = mag_of(mf_y);
            h   = mg > longint'(thr);
            m_last_pos = pos;
            m_n++;
            case (m_mode)
                1: if (m_n == L) m_mode = 2;
                2: if (h) begin
                    m_best = mg; m_best_pos = pos; m_trig = m_n; m_mode = 3;
                end
                3: begin
                    if (mg > m_best) begin
                        m_best = mg; m_best_pos = pos;
                    end
                    if (m_n - m_trig == WIN) begin
                        m_sync = 1; m_idx = m_best_pos; m_peak = m_best;
                        m_locked = 1; m_miss = 0; m_mode = 4;
                    end
                end
                4: if (pos == m_idx) begin
                    if (h) begin
                        m_sync = 1; m_peak = mg; m_miss = 0;
                    end else begin
                        m_miss++;
                        if (m_miss == MISS_MAX) begin
                            m_locked = 0; m_mode = 2;
                        end else begin
                            m_sync = 1;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("state", state_o, m_mode);
        check("mf_run", mf_run, m_run);
        check("sync_pulse", sync_pulse, m_sync);
        check("locked", locked, m_locked);
        check("sync_idx", sync_idx, m_idx);
        check("peak_val", peak_val, m_peak);
        if (sync_pulse) begin
            pulses++;
            last_pos = m_last_pos;
        end
    endtask

    function automatic logic signed [W3-1:0] pat_y(input int pos);
        if (pos == pa_pos) return pa_val;
        if (pos == pb_pos) return pb_val;
        return '0;
    endfunction

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            mf_y  = pat_y(m_n % PERIOD);
            mf_en = toggle ? ~mf_en : 1'b1;
            cyc();
        end
    endtask

    task automatic run_to_pulse(input int budget, output bit ok, output int ncyc);
        int p0;
        p0 = pulses;
        ok = 1'b0;
        ncyc = budget;
        for (int i = 0; i < budget; i++) begin
            mf_y  = pat_y(m_n % PERIOD);
            mf_en = toggle ? ~mf_en : 1'b1;
            cyc();
            if (pulses != p0) begin
                ok = 1'b1;
                ncyc = i + 1;
                break;
            end
        end
    endtask

    typedef struct {
        bit rst_n;
        bit start;
        bit abort;
        bit en;
        bit run;
        int st;
        bit lk;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n1, n2, tmp;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mf_en = 1'b0; mf_y = '0; thr = '0;
        for (int i = 0; i < 11; i++) begin
            rst_n = tbl[i].rst_n; start = tbl[i].start; abort = tbl[i].abort; mf_en = tbl[i].en;
            cyc();
            check("tbl_run", mf_run, tbl[i].run);
            check("tbl_state", state_o, tbl[i].st);
            check("tbl_locked", locked, tbl[i].lk);
            check("tbl_sync", sync_pulse, 0);
        end
        start = 1'b0; abort = 1'b0;

        // Fill: SEARCH exactly after the L-th qualified sample.
        rst_n = 1'b0; cyc();
        check("rst_state", state_o, 0);
        check("rst_peak", peak_val, 0);
        check("rst_idx", sync_idx, 0);
        rst_n = 1'b1; start = 1'b1; cyc(); start = 1'b0;
        check("t1_run", mf_run, 1);
        pulses = 0;
        run(L - 1);
        check("t1_fill_last", state_o, 1);
        run(1);
        check("t1_search", state_o, 2);
        check("t1_pulses", pulses, 0);
        check("t1_locked", locked, 0);

        // Acquire: 1500@100 then 2000@110, window closes at 164.
        thr = 32'd1000;
        pa_pos = 100; pa_val = 1500; pb_pos = 110; pb_val = 2000;
        run_to_pulse(5000, ok, n1);
        check("t2_found", ok, 1);
        check("t2_pulse_pos", last_pos, 164);
        check("t2_idx", sync_idx, 110);
        check("t2_peak", peak_val, 2000);
        check("t2_locked", locked, 1);
        check("t2_state", state_o, 4);

        // Track two periods of hits, then three silent periods.
        pa_pos = 110; pa_val = 2000; pb_pos = -1;
        pulses = 0;
        run(2 * PERIOD);
        check("t3_hits", pulses, 2);
        check("t3_hit_pos", last_pos, 110);
        pa_pos = -1;
        pulses = 0;
        run(3 * PERIOD);
        check("t3_flywheel", pulses, 2);
        check("t3_unlocked", locked, 0);
        check("t3_state", state_o, 2);

        // Most negative input saturates and still counts as a hit.
        thr = 32'h7FFF_FFFE;
        pa_pos = m_n % PERIOD; pa_val = {1'b1, {(W3-1){1'b0}}};
        tmp = pa_pos;
        run_to_pulse(200, ok, n1);
        check("t4_found", ok, 1);
        check("t4_peak", peak_val, MAXPOS);
        check("t4_idx", sync_idx, tmp);

        // Equal peaks keep the earliest; then the same with mf_en toggling.
        abort = 1'b1; cyc(); abort = 1'b0;
        check("t5_abort_state", state_o, 0);
        check("t5_abort_run", mf_run, 0);
        thr = 32'd1000;
        pa_pos = 200; pa_val = 1500; pb_pos = 210; pb_val = 1500;
        start = 1'b1; cyc(); start = 1'b0;
        run_to_pulse(6000, ok, n1);
        check("t5_found", ok, 1);
        check("t5_idx", sync_idx, 200);
        check("t5_peak", peak_val, 1500);
        abort = 1'b1; cyc(); abort = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        toggle = 1'b1;
        run_to_pulse(12000, ok, n2);
        toggle = 1'b0;
        check("t5t_found", ok, 1);
        check("t5t_idx", sync_idx, 200);
        check("t5t_stretched", (n2 >= 2 * n1 - 2), 1);

        // abort beats start in TRACK, then reset during PEAK.
        abort = 1'b1; start = 1'b1; mf_en = 1'b1; cyc(); abort = 1'b0; start = 1'b0;
        check("t6_state", state_o, 0);
        check("t6_run", mf_run, 0);
        check("t6_locked", locked, 0);
        check("t6_sync", sync_pulse, 0);
        start = 1'b1; cyc(); start = 1'b0;
        pa_pos = -1; pb_pos = -1;
        run(L);
        check("t6_search", state_o, 2);
        pa_pos = m_n % PERIOD; pa_val = 1500;
        run(3);
        check("t6_peak", state_o, 3);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        check("t6_rst_state", state_o, 0);
        check("t6_rst_run", mf_run, 0);
        check("t6_rst_idx", sync_idx, 0);
        check("t6_rst_peak", peak_val, 0);
        check("t6_rst_locked", locked, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 12000; i++) begin
            rst_n = ($urandom_range(0, 2999) != 0);
            start = ($urandom_range(0, 49) == 0);
            abort = ($urandom_range(0, 1999) == 0);
            mf_en = ($urandom_range(0, 3) != 0);
            thr   = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'd1000;
            tmp   = int'($urandom_range(0, 99));
            if (tmp < 2) begin
                tmp = int'($urandom_range(0, 6000)) - 3000;
            end else if (tmp == 2) begin
                tmp = int'(32'h8000_0000);
            end else begin
                tmp = int'($urandom_range(0, 1200)) - 600;
            end
            mf_y = tmp;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
